add3_pipe: RTL and testbench

//  Parametrised, pipelined three-operand adder for the Vedic divider datapath (partial-remainder/quotient-digit sums).

---
 rtl/add3_pkg.sv | 19 +
 rtl/add3_pipe_csa3to2.sv | 20 ++
 rtl/add3_pipe.sv | 147 ++++++++++++++
 tb/tb_add3_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add3_pkg.sv
// Package for the pipelined three-operand adder (add3_pipe).
// Holds the operand-interpretation mode type and the width helper used to
// size the internal carry-save / carry-propagate datapath.
package add3_pkg;

  // Operand interpretation for one transaction.
  typedef enum logic {
    ADD3_UNSIGNED = 1'b0,
    ADD3_SIGNED   = 1'b1
  } add3_mode_t;

  // Internal datapath width for a w-bit three-operand sum.
  // Two guard bits hold any sum of three w-bit values, signed or unsigned:
  // unsigned max 3*(2^w-1) < 2^(w+2); signed range fits a (w+2)-bit signed word.
  function automatic int ext3(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/add3_pipe_csa3to2.sv
// 3:2 carry-save compressor, N bits wide, purely combinational.
// Reduces three addends to a sum word and a carry word such that
// a + b + c == sum + (carry << 1) (modulo 2^(N+1)).
module csa3to2 #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  // Bitwise full-adder: parity for the sum, majority for the carry.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/add3_pipe.sv
// Pipelined three-operand adder for the divider datapath.
// Stage 1 sign/zero-extends the operands and compresses them with a 3:2
// carry-save step; stage 2 does the carry-propagate add, overflow detection
// and (optionally) saturation. Two-deep, strictly in-order, no drops.
//
// Build option: define ADD3_SAT_EN to clamp out_sum on overflow; without it
// out_sum is the sum modulo 2^WIDTH. out_ovf is reported in both builds.
//
// Handshake: a transfer happens on a side in a cycle where valid && ready are
// both high at the rising edge; valid never waits on ready, in_ready depends
// only on registered state and out_ready, and nothing on out_* depends on
// out_ready combinationally.
module add3_pipe
  import add3_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int EW = ext3(WIDTH);

  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage-1 registers
  logic          s1_valid;
  logic [EW-1:0] s1_sv;
  logic [EW-1:0] s1_cv;
  add3_mode_t    s1_signed;

  // Stage-1 combinational operands and compressor outputs
  add3_mode_t    in_mode;
  logic [EW-1:0] ext_a;
  logic [EW-1:0] ext_b;
  logic [EW-1:0] ext_c;
  logic [EW-1:0] csa_sum;
  logic [EW-1:0] csa_carry;

  // Stage-2 combinational result
  logic [EW-1:0]    full;
  logic             ovf_c;
  logic [WIDTH-1:0] res_c;

  // Pipeline control
  logic in_fire;
  logic s2_adv;

  // Stage 2 may load whenever the output register is empty or being drained.
  // Stage 1 may accept whenever it is empty or will move into stage 2.
  always_comb begin
    s2_adv   = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || (!out_valid || out_ready);
    in_fire  = in_valid && in_ready;
  end

  // Extend each operand by two guard bits according to the transaction mode.
  always_comb begin
    in_mode = in_signed ? ADD3_SIGNED : ADD3_UNSIGNED;
    ext_a   = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
    ext_b   = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
    ext_c   = {{2{in_signed & in_c[WIDTH-1]}}, in_c};
  end

  csa3to2 #(
    .N(EW)
  ) u_csa (
    .a    (ext_a),
    .b    (ext_b),
    .c    (ext_c),
    .sum  (csa_sum),
    .carry(csa_carry)
  );

  // Stage-1 register: capture carry-save words on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sv     <= '0;
      s1_cv     <= '0;
      s1_signed <= ADD3_UNSIGNED;
    end else begin
      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_sv     <= csa_sum;
        s1_cv     <= csa_carry;
        s1_signed <= in_mode;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Carry-propagate add, overflow test and result selection.
  // Signed: the sum fits iff the top three bits of the extended word agree.
  // Unsigned: the sum fits iff both guard bits are clear.
  always_comb begin
    full  = s1_sv + (s1_cv << 1);
    ovf_c = 1'b0;
    res_c = full[WIDTH-1:0];
    if (s1_signed == ADD3_SIGNED) begin
      ovf_c = !((&full[EW-1:WIDTH-1]) || !(|full[EW-1:WIDTH-1]));
    end else begin
      ovf_c = |full[EW-1:WIDTH];
    end
`ifdef ADD3_SAT_EN
    if (ovf_c) begin
      if (s1_signed == ADD3_SIGNED) begin
        res_c = full[EW-1] ? SMIN : SMAX;
      end else begin
        res_c = UMAX;
      end
    end
`endif
  end

  // Output register: load from stage 1, otherwise drain on out_ready;
  // contents hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        out_sum   <= res_c;
        out_ovf   <= ovf_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add3_pipe.sv
// Bench for add3_pipe: a WIDTH=2 instance for directed corner cases, burst
// stalls and mid-flight reset, plus a WIDTH=16 instance for random traffic.
// Expected results come from an integer-arithmetic model of the three-operand
// sum; monitors push on input transfers and pop/compare on output transfers.
module tb_add3_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic        in_valid2, in_ready2, in_signed2, out_valid2, out_ready2, out_ovf2;
  logic [1:0]  in_a2, in_b2, in_c2, out_sum2;
  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, out_ovf16;
  logic [15:0] in_a16, in_b16, in_c16, out_sum16;

  add3_pipe #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_signed(in_signed2),
    .in_a(in_a2), .in_b(in_b2), .in_c(in_c2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .out_ovf(out_ovf2)
  );

  add3_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_signed(in_signed16),
    .in_a(in_a16), .in_b(in_b16), .in_c(in_c16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .out_ovf(out_ovf16)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q2[$];
  logic [16:0] exp_q16[$];
  int   pop_cnt2 = 0;
  int   pop_cnt16 = 0;
  bit   saw_block2 = 1'b0;
  bit   hold2 = 1'b0;
  bit   hold16 = 1'b0;
  logic [2:0]  held2;
  logic [16:0] held16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true integer sum of the three operands under the given mode,
  // range test, optional clamp, then reduction to w bits. Returns {ovf, sum}.
  function automatic logic [16:0] ref_model(input int w, input bit sgn,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
    longint m, va, vb, vc, t, lo, hi, r;
    logic ovf;
    m  = longint'(1) << w;
    va = longint'(a); vb = longint'(b); vc = longint'(c);
    if (sgn && a[w-1]) va = va - m;
    if (sgn && b[w-1]) vb = vb - m;
    if (sgn && c[w-1]) vc = vc - m;
    t = va + vb + vc;
    if (sgn) begin
      lo = -(m / 2);
      hi = m / 2 - 1;
    end else begin
      lo = 0;
      hi = m - 1;
    end
    ovf = (t < lo) || (t > hi);
    r = t;
`ifdef ADD3_SAT_EN
    if (t > hi) r = hi;
    else if (t < lo) r = lo;
`endif
    r = r & (m - 1);
    return {ovf, 16'(r)};
  endfunction

  // Monitor for the 2-bit instance: push on input transfer, compare on pop,
  // and require output stability across a stalled cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q2.delete();
      hold2 = 1'b0;
    end else begin
      if (hold2) begin
        check("u2_stall_valid", {31'd0, out_valid2}, 32'd1);
        check("u2_stall_data", {29'd0, out_ovf2, out_sum2}, {29'd0, held2});
      end
      if (in_valid2 && !in_ready2) saw_block2 = 1'b1;
      if (out_valid2 && out_ready2) begin
        pop_cnt2++;
        if (exp_q2.size() == 0) check("u2_pop_empty", 32'd1, 32'd0);
        else check("u2_result", {15'd0, out_ovf2, 14'd0, out_sum2}, {15'd0, exp_q2.pop_front()});
      end
      if (in_valid2 && in_ready2)
        exp_q2.push_back(ref_model(2, in_signed2, {14'd0, in_a2}, {14'd0, in_b2}, {14'd0, in_c2}));
      hold2 = out_valid2 && !out_ready2;
      held2 = {out_ovf2, out_sum2};
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q16.delete();
      hold16 = 1'b0;
    end else begin
      if (hold16) check("u16_stall_data", {14'd0, out_valid16, out_ovf16, out_sum16}, {14'd0, 1'b1, held16});
      if (out_valid16 && out_ready16) begin
        pop_cnt16++;
        if (exp_q16.size() == 0) check("u16_pop_empty", 32'd1, 32'd0);
        else check("u16_result", {15'd0, out_ovf16, out_sum16}, {15'd0, exp_q16.pop_front()});
      end
      if (in_valid16 && in_ready16)
        exp_q16.push_back(ref_model(16, in_signed16, in_a16, in_b16, in_c16));
      hold16 = out_valid16 && !out_ready16;
      held16 = {out_ovf16, out_sum16};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send2(input bit s, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    int n = 0;
    in_signed2 = s; in_a2 = a; in_b2 = b; in_c2 = c; in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready2) check("u2_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic wait_out2();
    int n = 0;
    while (!out_valid2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid2) check("u2_out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string tag, input bit s, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] exp_sum, input logic exp_ovf);
    out_ready2 = 1'b1;
    send2(s, a, b, c);
    wait_out2();
    check({tag, "_sum"}, {30'd0, out_sum2}, {30'd0, exp_sum});
    check({tag, "_ovf"}, {31'd0, out_ovf2}, {31'd0, exp_ovf});
    @(posedge clk); #1;
  endtask

  // Watchdog: ends the run if something stops making progress.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_valid2 = 1'b0; in_signed2 = 1'b0; in_a2 = '0; in_b2 = '0; in_c2 = '0; out_ready2 = 1'b0;
    in_valid16 = 1'b0; in_signed16 = 1'b0; in_a16 = '0; in_b16 = '0; in_c16 = '0; out_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid2", {31'd0, out_valid2}, 32'd0);
    check("rst_in_ready2", {31'd0, in_ready2}, 32'd1);
    check("rst_out_sum2", {30'd0, out_sum2}, 32'd0);
    check("rst_out_ovf2", {31'd0, out_ovf2}, 32'd0);
    check("rst_out_valid16", {31'd0, out_valid16}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: unsigned 1+1+0 appears exactly two cycles after the transfer cycle.
    out_ready2 = 1'b1;
    send2(1'b0, 2'd1, 2'd1, 2'd0);
    check("lat_cycle1_valid", {31'd0, out_valid2}, 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", {31'd0, out_valid2}, 32'd1);
    check("lat_sum", {30'd0, out_sum2}, 32'd2);
    check("lat_ovf", {31'd0, out_ovf2}, 32'd0);
    @(posedge clk); #1;
    check("lat_drained", {31'd0, out_valid2}, 32'd0);

    // Corner vectors on the 2-bit instance.
`ifdef ADD3_SAT_EN
    run_vec("u333", 1'b0, 2'd3, 2'd3, 2'd3, 2'b11, 1'b1);
    run_vec("s111", 1'b1, 2'd1, 2'd1, 2'd1, 2'b01, 1'b1);
`else
    run_vec("u333", 1'b0, 2'd3, 2'd3, 2'd3, 2'b01, 1'b1);
    run_vec("s111", 1'b1, 2'd1, 2'd1, 2'd1, 2'b11, 1'b1);
`endif
    run_vec("sm2x3", 1'b1, 2'b10, 2'b10, 2'b10, 2'b10, 1'b1);
    run_vec("u300", 1'b0, 2'd3, 2'd0, 2'd0, 2'b11, 1'b0);
    run_vec("sm1m1", 1'b1, 2'b11, 2'b11, 2'b00, 2'b10, 1'b0);
    run_vec("s100", 1'b1, 2'd1, 2'd0, 2'd0, 2'b01, 1'b0);

    // Burst of 8 with a 3-cycle output stall in the middle.
    begin
      int base;
      int n;
      base = pop_cnt2;
      saw_block2 = 1'b0;
      fork
        begin
          for (int i = 0; i < 8; i++)
            send2(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        begin
          out_ready2 = 1'b1;
          repeat (3) @(posedge clk);
          #1 out_ready2 = 1'b0;
          repeat (3) @(posedge clk);
          #1 out_ready2 = 1'b1;
        end
      join
      n = 0;
      while (exp_q2.size() != 0 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      check("burst_in_ready_dropped", {31'd0, saw_block2}, 32'd1);
      check("burst_count", 32'(pop_cnt2 - base), 32'd8);
      check("burst_queue_empty", 32'(exp_q2.size()), 32'd0);
    end

    // Reset with two transactions in flight.
    out_ready2 = 1'b0;
    send2(1'b0, 2'd1, 2'd2, 2'd0);
    send2(1'b1, 2'd3, 2'd1, 2'd2);
    @(posedge clk); #1;
    check("pre_rst_full_valid", {31'd0, out_valid2}, 32'd1);
    check("pre_rst_full_ready", {31'd0, in_ready2}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid2}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready2}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready2 = 1'b1;
    begin
      bit seen = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        if (out_valid2) seen = 1'b1;
      end
      check("post_rst_no_stale", {31'd0, seen}, 32'd0);
    end
    run_vec("post_rst_u120", 1'b0, 2'd1, 2'd2, 2'd0, 2'b11, 1'b0);

    // Random traffic on the 16-bit instance with random output back-pressure.
    begin
      int sent = 0;
      int guard = 0;
      bit acc = 1'b0;
      while (sent < 10000 && guard < 60000) begin
        @(posedge clk); #1;
        guard++;
        if (acc) in_valid16 = 1'b0;
        out_ready16 = ($urandom_range(0, 3) != 0);
        if (!in_valid16 && $urandom_range(0, 3) != 0) begin
          in_signed16 = 1'($urandom_range(0, 1));
          in_a16 = 16'($urandom);
          in_b16 = 16'($urandom);
          in_c16 = 16'($urandom);
          in_valid16 = 1'b1;
        end
        @(negedge clk);
        acc = in_valid16 && in_ready16;
        if (acc) sent++;
      end
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      out_ready16 = 1'b1;
      check("rand_all_sent", 32'(sent), 32'd10000);
      guard = 0;
      while (exp_q16.size() != 0 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
      check("rand_queue_empty", 32'(exp_q16.size()), 32'd0);
      check("rand_pop_count", 32'(pop_cnt16), 32'(sent));
      check("rand_idle_valid", {31'd0, out_valid16}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
